aes_inv_cipher: RTL and testbench

Iterative AES-128 inverse cipher: accepts one 128-bit ciphertext block, performs the FIPS-197 inverse cipher over ten rounds at one round per clock, and returns the plaintext. It consumes the same `round_key[0:10]` array produced by `key_expansion`, applying the keys in reverse order. It is the decryption counterpart of the forward `aes` core and is the building block for the ECB/CBC decrypt paths, which the CTR path does not need.

---
 rtl/aes_inv_cipher.sv | 166 ++++++++++++++++
 tb/tb_aes_inv_cipher.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher: ten rounds at one round per enabled clock.
// Round keys arrive in forward order and are indexed from 10 down to 0.

module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] INV_SBOX_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign y = INV_SBOX_TABLE[a];
endmodule

module aes_inv_cipher (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [127:0] ciphertext_i,
  input  logic [127:0] round_key_i [0:10],
  output logic         valid_o,
  output logic [127:0] plaintext_o
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_t;

  fsm_t         fsm_reg, fsm_next;
  logic [127:0] state_reg, state_next;
  logic [3:0]   round_cnt_reg, round_cnt_next;
  logic [127:0] plaintext_reg, plaintext_next;
  logic         valid_reg, valid_next;

  logic [127:0] shifted;
  logic [127:0] subbed;
  logic [127:0] round_out;
  logic [127:0] final_out;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Inverse mix coefficients built from x2/x4/x8 partial products.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  // Byte index is 4*column + row; row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  assign shifted = inv_shift_rows(state_reg);

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
      inv_sbox u_inv_sbox (
        .a(shifted[127-8*gi -: 8]),
        .y(subbed[127-8*gi -: 8])
      );
    end
  endgenerate

  assign round_out = inv_mix_columns(subbed ^ round_key_i[round_cnt_reg]);
  assign final_out = subbed ^ round_key_i[0];

  always_comb begin
    fsm_next       = fsm_reg;
    state_next     = state_reg;
    round_cnt_next = round_cnt_reg;
    plaintext_next = plaintext_reg;
    valid_next     = 1'b0;
    case (fsm_reg)
      IDLE: begin
        if (valid_i) begin
          state_next     = ciphertext_i ^ round_key_i[10];
          round_cnt_next = 4'd9;
          fsm_next       = ROUND;
        end
      end
      ROUND: begin
        state_next     = round_out;
        round_cnt_next = round_cnt_reg - 4'd1;
        if (round_cnt_reg == 4'd1) begin
          fsm_next = FINAL;
        end
      end
      FINAL: begin
        plaintext_next = final_out;
        valid_next     = 1'b1;
        fsm_next       = IDLE;
      end
      default: fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg       <= IDLE;
      state_reg     <= '0;
      round_cnt_reg <= '0;
      plaintext_reg <= '0;
      valid_reg     <= 1'b0;
    end else if (en) begin
      fsm_reg       <= fsm_next;
      state_reg     <= state_next;
      round_cnt_reg <= round_cnt_next;
      plaintext_reg <= plaintext_next;
      valid_reg     <= valid_next;
    end
  end

  assign ready_o     = (fsm_reg == IDLE);
  assign valid_o     = valid_reg;
  assign plaintext_o = plaintext_reg;
endmodule

// File: tb/tb_aes_inv_cipher.sv
// Scoreboarded bench for aes_inv_cipher: directed FIPS-197 vectors, busy/stall/reset
// cases and a forward-cipher round trip; expectations are queued, a monitor checks them.

module tb_aes_inv_cipher;
  logic         clk;
  logic         rst;
  logic         en;
  logic         valid_i;
  logic         ready_o;
  logic [127:0] ciphertext_i;
  logic [127:0] rk [0:10];
  logic         valid_o;
  logic [127:0] plaintext_o;

  aes_inv_cipher dut (
    .clk(clk), .rst(rst), .en(en), .valid_i(valid_i), .ready_o(ready_o),
    .ciphertext_i(ciphertext_i), .round_key_i(rk),
    .valid_o(valid_o), .plaintext_o(plaintext_o)
  );

  typedef struct {
    logic [127:0] pt;
    int           first_cyc;
    int           len;
  } exp_t;

  exp_t       exp_q[$];
  int         n_vec = 0;
  int         n_bad = 0;
  int         cyc = 0;
  bit         in_pulse = 0;
  logic [7:0] sb [0:255];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference arithmetic (independent of the DUT) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] s, t;
    logic [7:0]   a0, a1, a2, a3;
    s = pt ^ rk[0];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = sb[s[127-8*i -: 8]];
      t = s;
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[127-8*(4*c+r) -: 8] = t[127-8*(4*((c+r)%4)+r) -: 8];
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127-32*c -: 8];
          a1 = s[119-32*c -: 8];
          a2 = s[111-32*c -: 8];
          a3 = s[103-32*c -: 8];
          s[127-32*c -: 32] = {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
                               a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
                               a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
                               gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
        end
      end
      s = s ^ rk[rnd];
    end
    return s;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    exp_t cur;
    bit   cur_ok;
    int   plen;
    cur_ok = 0;
    plen   = 0;
    forever begin
      @(negedge clk);
      if (valid_o && !in_pulse) begin
        in_pulse = 1;
        plen     = 1;
        n_vec++;
        if (exp_q.size() == 0) begin
          cur_ok = 0;
          n_bad++;
          $display("FAIL unexpected_valid: valid_o high at cycle %0d, plaintext %h, required no output", cyc, plaintext_o);
        end else begin
          cur    = exp_q.pop_front();
          cur_ok = 1;
          if (plaintext_o !== cur.pt) begin
            n_bad++;
            $display("FAIL plaintext: got %h, required %h", plaintext_o, cur.pt);
          end
          n_vec++;
          if (cyc != cur.first_cyc) begin
            n_bad++;
            $display("FAIL latency: valid_o at cycle %0d, required cycle %0d", cyc, cur.first_cyc);
          end
          $display("output pt=%h at cycle %0d", plaintext_o, cyc);
        end
      end else if (valid_o) begin
        plen++;
      end else if (in_pulse) begin
        in_pulse = 0;
        if (cur_ok) begin
          n_vec++;
          if (plen != cur.len) begin
            n_bad++;
            $display("FAIL pulse_width: valid_o high %0d cycles, required %0d", plen, cur.len);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] req);
    n_vec++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end else begin
      $display("check %s = %h", name, got);
    end
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!ready_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("ready_before_send", 128'(ready_o), 128'd1);
  endtask

  task automatic send(input logic [127:0] ct, input logic [127:0] pt,
                      input int extra, input int len, input bit push);
    exp_t e;
    wait_ready();
    valid_i      = 1'b1;
    ciphertext_i = ct;
    if (push) begin
      e.pt        = pt;
      e.first_cyc = cyc + 11 + extra;
      e.len       = len;
      exp_q.push_back(e);
    end
    $display("input ct=%h at cycle %0d", ct, cyc);
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || in_pulse || valid_o) && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    n_vec++;
    if (k >= 100) begin
      n_bad++;
      $display("FAIL timeout: %0d expected outputs still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    exp_t e;
    logic [127:0] key, pt;
    int k;
    rst = 1'b1; en = 1'b1; valid_i = 1'b0; ciphertext_i = '0;
    for (int r = 0; r <= 10; r++) rk[r] = '0;
    build_sbox();
    load_key(C1_KEY);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_ready", 128'(ready_o), 128'd1);
    check("reset_valid", 128'(valid_o), 128'd0);
    check("reset_plaintext", plaintext_o, 128'd0);

    // FIPS-197 C.1
    send(C1_CT, C1_PT, 0, 1, 1);
    wait_idle();

    // C.1 then B with valid_i held high throughout
    wait_ready();
    load_key(C1_KEY);
    valid_i = 1'b1; ciphertext_i = C1_CT;
    e.pt = C1_PT; e.first_cyc = cyc + 11; e.len = 1;
    exp_q.push_back(e);
    repeat (11) @(negedge clk);
    load_key(B_KEY);
    ciphertext_i = B_CT;
    e.pt = B_PT; e.first_cyc = cyc + 11; e.len = 1;
    exp_q.push_back(e);
    @(negedge clk);
    valid_i = 1'b0;
    wait_idle();

    // Busy ignore
    load_key(C1_KEY);
    send(C1_CT, C1_PT, 0, 1, 1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      valid_i = 1'b1;
      ciphertext_i = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    valid_i = 1'b0;
    wait_idle();

    // Stall: 4 cycles mid-round, 2 cycles while valid_o is high
    send(C1_CT, C1_PT, 4, 3, 1);
    repeat (2) @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    en = 1'b1;
    k = 0;
    while (!valid_o && k < 40) begin
      @(negedge clk);
      k++;
    end
    en = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    wait_idle();

    // Reset mid-operation
    send(C1_CT, C1_PT, 0, 1, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_ready", 128'(ready_o), 128'd1);
    check("midreset_valid", 128'(valid_o), 128'd0);
    check("midreset_plaintext", plaintext_o, 128'd0);
    repeat (15) @(negedge clk);
    send(C1_CT, C1_PT, 0, 1, 1);
    wait_idle();

    // Round trip against the bench's forward cipher
    for (int i = 0; i < 20; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      load_key(key);
      send(encrypt(pt), pt, 0, 1, 1);
      wait_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
